// File: rtl/dec_pkg.sv
// -----------------------------------------------------------------------------
// dec_pkg
// Shared types and constants for the one-hot decoder family.
//   state_t     : controller states IDLE / DIRECT / SCAN
//   MODE_DIRECT : value of the mode input that selects host-indexed decoding
//   MODE_SCAN   : value of the mode input that selects the self-stepping scan
// -----------------------------------------------------------------------------
package dec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_dec.sv
// -----------------------------------------------------------------------------
// onehot_dec
// Combinational SEL_W-to-2^SEL_W one-hot decoder with a valid gate.
// Ports:
//   idx  in   SEL_W   index to decode
//   vld  in   1       1: y = 1 << idx, 0: y = 0
//   y    out  OUT_W   one-hot (or all-zero) result
// -----------------------------------------------------------------------------
module onehot_dec #(
    parameter  int SEL_W = 3,
    localparam int OUT_W = 1 << SEL_W
) (
    input  logic [SEL_W-1:0] idx,
    input  logic             vld,
    output logic [OUT_W-1:0] y
);

    assign y = vld ? (OUT_W'(1) << idx) : '0;

endmodule

// File: rtl/dec_scan_n.sv
// -----------------------------------------------------------------------------
// dec_scan_n
// Registered one-hot decoder with enable and two modes:
//   DIRECT : d follows a host-supplied index (loaded on sel_vld).
//   SCAN   : d steps through the output lines, each held for dwell+1 cycles.
// Optional feature macro: DEC_SKIP_MASK_EN adds scan_mask so SCAN skips lanes.
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous, active-high reset
//   en         in   1        0: outputs to zero, controller to IDLE
//   mode       in   1        MODE_DIRECT / MODE_SCAN
//   sel        in   SEL_W    DIRECT index
//   sel_vld    in   1        load sel (DIRECT only)
//   dwell      in   DWELL_W  slot length - 1, sampled at each slot start
//   d          out  OUT_W    registered one-hot (or all-zero) output
//   cur_idx    out  SEL_W    index currently driven on d
//   wrap       out  1        pulse when the scan returns to its first slot
//   busy       out  1        1 while in DIRECT or SCAN
//   scan_mask  in   OUT_W    (DEC_SKIP_MASK_EN only) bit i = 1 skips lane i
// -----------------------------------------------------------------------------
module dec_scan_n
    import dec_pkg::*;
#(
    parameter  int SEL_W   = 3,
    parameter  int DWELL_W = 8,
    localparam int OUT_W   = 1 << SEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic               sel_vld,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   d,
    output logic [SEL_W-1:0]   cur_idx,
    output logic               wrap,
    output logic               busy
`ifdef DEC_SKIP_MASK_EN
    ,
    input  logic [OUT_W-1:0]   scan_mask
`endif
);

    state_t             state, state_nx;
    logic [DWELL_W-1:0] cnt, cnt_nx;
    logic [SEL_W-1:0]   idx_nx;
    logic               vld_nx;
    logic               wrap_nx;
    logic [OUT_W-1:0]   dec_y;
    logic [OUT_W-1:0]   mask;

    logic [SEL_W-1:0]   first_idx, next_idx;
    logic               first_ok, next_ok;

`ifdef DEC_SKIP_MASK_EN
    assign mask = scan_mask;
`else
    // Without the mask every lane is eligible, so the search below reduces to
    // a plain increment with wrap at OUT_W-1.
    assign mask = '0;
`endif

    // Lane search. Loops run from the far end toward the near end so the last
    // hit written is the nearest one, which avoids any early exit.
    //   first_idx : lowest unmasked lane (slot used on SCAN entry)
    //   next_idx  : next unmasked lane after cur_idx, circularly; an offset of
    //               OUT_W lands back on cur_idx when it is the only open lane.
    always_comb begin
        logic [SEL_W-1:0] cand;
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned -- that is what keeps a latch from appearing.
        cand      = '0;
        first_ok  = 1'b0;
        first_idx = '0;
        next_ok   = 1'b0;
        next_idx  = cur_idx;
        for (int k = OUT_W - 1; k >= 0; k--) begin
            if (!mask[k]) begin
                first_ok  = 1'b1;
                first_idx = SEL_W'(k);
            end
        end
        for (int k = OUT_W; k >= 1; k--) begin
            cand = cur_idx + SEL_W'(k);
            if (!mask[cand]) begin
                next_ok  = 1'b1;
                next_idx = cand;
            end
        end
    end

    // Next-state / next-output logic. idx_nx/vld_nx feed a single decoder,
    // so the DIRECT and SCAN paths share it and d can never be multi-hot.
    always_comb begin
        state_nx = state;
        idx_nx   = cur_idx;
        vld_nx   = |d;
        cnt_nx   = cnt;
        wrap_nx  = 1'b0;

        if (!en) begin
            state_nx = IDLE;
            vld_nx   = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mode == MODE_SCAN) begin
                        state_nx = SCAN;
                        cnt_nx   = dwell;
                        idx_nx   = first_ok ? first_idx : cur_idx;
                        vld_nx   = first_ok;
                    end else begin
                        state_nx = DIRECT;
                        vld_nx   = 1'b0;
                    end
                end

                DIRECT: begin
                    if (mode == MODE_SCAN) begin
                        state_nx = SCAN;
                        cnt_nx   = dwell;
                        idx_nx   = first_ok ? first_idx : cur_idx;
                        vld_nx   = first_ok;
                    end else if (sel_vld) begin
                        idx_nx = sel;
                        vld_nx = 1'b1;
                    end
                end

                SCAN: begin
                    if (mode == MODE_DIRECT) begin
                        // d and cur_idx hold until the host loads an index.
                        state_nx = DIRECT;
                    end else if (cnt == '0) begin
                        // Slot boundary: dwell is sampled here and only here.
                        cnt_nx = dwell;
                        if (next_ok) begin
                            idx_nx  = next_idx;
                            vld_nx  = 1'b1;
                            wrap_nx = (next_idx <= cur_idx);
                        end else begin
                            vld_nx  = 1'b0;
                        end
                    end else begin
                        cnt_nx = cnt - DWELL_W'(1);
                    end
                end

                default: begin
                    state_nx = IDLE;
                    vld_nx   = 1'b0;
                end
            endcase
        end
    end

    onehot_dec #(.SEL_W(SEL_W)) u_dec (
        .idx (idx_nx),
        .vld (vld_nx),
        .y   (dec_y)
    );

    // NOTE: state registers use non-blocking assignments so every flop in
    // this block samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            d       <= '0;
            cur_idx <= '0;
            wrap    <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_nx;
            d       <= dec_y;
            cur_idx <= idx_nx;
            wrap    <= wrap_nx;
            cnt     <= cnt_nx;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dec_scan_n.sv
// -----------------------------------------------------------------------------
// tb_dec_scan_n
// Directed self-checking bench for dec_scan_n (SEL_W=3, DWELL_W=8).
// Inputs change 1 time unit after the rising edge; outputs are compared at
// that same point, i.e. showing the result of the edge just taken.
// Define DEC_SKIP_MASK_EN to also exercise the scan_mask feature.
// -----------------------------------------------------------------------------
module tb_dec_scan_n;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic [2:0] sel;
    logic       sel_vld;
    logic [7:0] dwell;
    logic [7:0] d;
    logic [2:0] cur_idx;
    logic       wrap;
    logic       busy;
`ifdef DEC_SKIP_MASK_EN
    logic [7:0] scan_mask;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dec_scan_n #(.SEL_W(3), .DWELL_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .sel     (sel),
        .sel_vld (sel_vld),
        .dwell   (dwell),
        .d       (d),
        .cur_idx (cur_idx),
        .wrap    (wrap),
        .busy    (busy)
`ifdef DEC_SKIP_MASK_EN
        ,
        .scan_mask (scan_mask)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; sel_vld = 1'b0; dwell = '0;
`ifdef DEC_SKIP_MASK_EN
        scan_mask = '0;
`endif
        step();
        step();
        n_cmp++;
        if ({d, cur_idx, wrap, busy} !== 13'b0) begin
            $display("FAIL reset_values: d=%b idx=%0d wrap=%b busy=%b expected all zero",
                     d, cur_idx, wrap, busy);
            n_bad++;
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0 || d !== 8'h00) begin
            $display("FAIL idle_after_reset: busy=%b d=%b expected 0 / 00000000", busy, d);
            n_bad++;
        end
    endtask

    task automatic test_direct();
        en = 1'b1; mode = 1'b0; sel_vld = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b1 || d !== 8'h00) begin
            $display("FAIL direct_entry: busy=%b d=%b expected 1 / 00000000", busy, d);
            n_bad++;
        end
        sel = 3'd5; sel_vld = 1'b1;
        #1;
        n_cmp++;
        if (d !== 8'h00) begin
            $display("FAIL direct_latency: d=%b before edge expected 00000000", d);
            n_bad++;
        end
        step();
        n_cmp++;
        if (d !== 8'b0010_0000 || cur_idx !== 3'd5) begin
            $display("FAIL direct_sel5: d=%b idx=%0d expected 00100000 / 5", d, cur_idx);
            n_bad++;
        end
        sel_vld = 1'b0; sel = 3'd2;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (d !== 8'b0010_0000 || cur_idx !== 3'd5) begin
                $display("FAIL direct_hold[%0d]: d=%b idx=%0d expected 00100000 / 5", i, d, cur_idx);
                n_bad++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] sels [3];
        logic [7:0] exps [3];
        sels = '{3'd0, 3'd7, 3'd3};
        exps = '{8'b0000_0001, 8'b1000_0000, 8'b0000_1000};
        sel_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel = sels[i];
            step();
            n_cmp++;
            if (d !== exps[i] || cur_idx !== sels[i]) begin
                $display("FAIL direct_b2b[%0d]: d=%b idx=%0d expected %b / %0d",
                         i, d, cur_idx, exps[i], sels[i]);
                n_bad++;
            end
        end
        sel_vld = 1'b0;
    endtask

    // Entered from DIRECT; dwell=2 gives 3 cycles per slot, 24 per lap.
    task automatic test_scan_dwell2();
        logic [7:0] exp_d;
        logic       exp_w;
        mode = 1'b1; dwell = 8'd2;
        for (int i = 0; i < 48; i++) begin
            step();
            exp_d = 8'd1 << ((i / 3) % 8);
            exp_w = (i % 24 == 0) && (i != 0);
            n_cmp++;
            if (d !== exp_d || wrap !== exp_w) begin
                $display("FAIL scan_dwell2[%0d]: d=%b wrap=%b expected %b / %b",
                         i, d, wrap, exp_d, exp_w);
                n_bad++;
            end
        end
        // Next edge would wrap; en=0 must win and force d=0, wrap=0.
        en = 1'b0;
        step();
        n_cmp++;
        if (d !== 8'h00 || wrap !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL scan_disable: d=%b wrap=%b busy=%b expected 00000000 / 0 / 0",
                     d, wrap, busy);
            n_bad++;
        end
    endtask

    task automatic test_scan_dwell0();
        logic [2:0] exp_i;
        logic [2:0] seq [7];
        en = 1'b1; mode = 1'b1; dwell = 8'd0;
        for (int i = 0; i < 10; i++) begin
            step();
            exp_i = 3'(i % 8);
            n_cmp++;
            if (cur_idx !== exp_i || d !== (8'd1 << exp_i) || wrap !== (i == 8)) begin
                $display("FAIL scan_dwell0[%0d]: idx=%0d d=%b wrap=%b expected %0d / %b / %b",
                         i, cur_idx, d, wrap, exp_i, 8'd1 << exp_i, i == 8);
                n_bad++;
            end
        end
        // At idx 1 with counter 0: dwell=3 applies to slot 2 (4 cycles). A
        // further change to 1 during slot 2 only shortens slot 3.
        dwell = 8'd3;
        seq = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4};
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 0) dwell = 8'd1;
            n_cmp++;
            if (cur_idx !== seq[i] || d !== (8'd1 << seq[i])) begin
                $display("FAIL dwell_change[%0d]: idx=%0d d=%b expected %0d", i, cur_idx, d, seq[i]);
                n_bad++;
            end
        end
    endtask

    task automatic test_mode_switch();
        en = 1'b0;
        step();
        en = 1'b1; mode = 1'b1; dwell = 8'd0; sel = 3'd3; sel_vld = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            n_cmp++;
            if (cur_idx !== 3'(i) || d !== (8'd1 << i)) begin
                $display("FAIL scan_ignores_sel[%0d]: idx=%0d d=%b expected %0d", i, cur_idx, d, i);
                n_bad++;
            end
        end
        sel_vld = 1'b0; mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (d !== 8'b0100_0000 || cur_idx !== 3'd6 || busy !== 1'b1) begin
                $display("FAIL scan_to_direct_hold[%0d]: d=%b idx=%0d busy=%b expected 01000000 / 6 / 1",
                         i, d, cur_idx, busy);
                n_bad++;
            end
        end
        sel = 3'd1; sel_vld = 1'b1;
        step();
        n_cmp++;
        if (d !== 8'b0000_0010 || cur_idx !== 3'd1) begin
            $display("FAIL direct_after_scan: d=%b idx=%0d expected 00000010 / 1", d, cur_idx);
            n_bad++;
        end
        sel_vld = 1'b0; mode = 1'b1;
        step();
        n_cmp++;
        if (d !== 8'b0000_0001 || cur_idx !== 3'd0 || wrap !== 1'b0) begin
            $display("FAIL direct_to_scan_restart: d=%b idx=%0d wrap=%b expected 00000001 / 0 / 0",
                     d, cur_idx, wrap);
            n_bad++;
        end
    endtask

    task automatic test_reset_mid_scan();
        step(); step(); step();
        n_cmp++;
        if (cur_idx !== 3'd3 || d !== 8'b0000_1000) begin
            $display("FAIL pre_reset_scan: idx=%0d d=%b expected 3 / 00001000", cur_idx, d);
            n_bad++;
        end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (d !== 8'h00 || cur_idx !== 3'd0 || busy !== 1'b0 || wrap !== 1'b0) begin
            $display("FAIL async_reset: d=%b idx=%0d busy=%b wrap=%b expected all zero",
                     d, cur_idx, busy, wrap);
            n_bad++;
        end
        en = 1'b0;
        step();
        rst = 1'b0;
        step();
        n_cmp++;
        if (d !== 8'h00 || busy !== 1'b0) begin
            $display("FAIL idle_after_async_reset: d=%b busy=%b expected 00000000 / 0", d, busy);
            n_bad++;
        end
    endtask

`ifdef DEC_SKIP_MASK_EN
    task automatic test_mask();
        logic [2:0] seq  [6];
        logic       wseq [6];
        scan_mask = 8'b1010_1010; en = 1'b1; mode = 1'b1; dwell = 8'd0;
        seq  = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd2};
        wseq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (cur_idx !== seq[i] || d !== (8'd1 << seq[i]) || wrap !== wseq[i]) begin
                $display("FAIL mask_aa[%0d]: idx=%0d d=%b wrap=%b expected %0d / %b",
                         i, cur_idx, d, wrap, seq[i], wseq[i]);
                n_bad++;
            end
        end
        scan_mask = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (d !== 8'h00 || wrap !== 1'b0 || cur_idx !== 3'd2) begin
                $display("FAIL mask_all[%0d]: d=%b wrap=%b idx=%0d expected 00000000 / 0 / 2",
                         i, d, wrap, cur_idx);
                n_bad++;
            end
        end
        en = 1'b0;
        step();
        scan_mask = 8'b0000_0111; en = 1'b1;
        seq  = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3};
        wseq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (cur_idx !== seq[i] || d !== (8'd1 << seq[i]) || wrap !== wseq[i]) begin
                $display("FAIL mask_07[%0d]: idx=%0d d=%b wrap=%b expected %0d / %b",
                         i, cur_idx, d, wrap, seq[i], wseq[i]);
                n_bad++;
            end
        end
        mode = 1'b0;
        step();
        sel = 3'd1; sel_vld = 1'b1;
        step();
        sel_vld = 1'b0;
        n_cmp++;
        if (d !== 8'b0000_0010 || cur_idx !== 3'd1) begin
            $display("FAIL mask_direct: d=%b idx=%0d expected 00000010 / 1", d, cur_idx);
            n_bad++;
        end
        scan_mask = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_direct();
        test_back_to_back();
        test_scan_dwell2();
        test_scan_dwell0();
        test_mode_switch();
        test_reset_mid_scan();
`ifdef DEC_SKIP_MASK_EN
        test_mask();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
